// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, width defaults and the
// scheduler state encoding used by alu_sched.
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OPW_DEF  = 8;

    // RV32I ALU opcode encoding; anything above ALU_OP_LAST is illegal
    localparam logic [7:0] ALU_ADD     = 8'd0;
    localparam logic [7:0] ALU_SUB     = 8'd1;
    localparam logic [7:0] ALU_AND     = 8'd2;
    localparam logic [7:0] ALU_OR      = 8'd3;
    localparam logic [7:0] ALU_XOR     = 8'd4;
    localparam logic [7:0] ALU_SLL     = 8'd5;
    localparam logic [7:0] ALU_SLT     = 8'd6;
    localparam logic [7:0] ALU_SLTU    = 8'd7;
    localparam logic [7:0] ALU_SRA     = 8'd8;
    localparam logic [7:0] ALU_SRL     = 8'd9;
    localparam logic [7:0] ALU_OP_LAST = 8'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter. A lone request always wins; when both
// ports request, prio names the winner. The priority state itself lives
// in the instantiating scheduler.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    // One-hot (or zero) grant from the request pair and tie-break bit
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (prio) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// address/branch-compare unit (port 1). One operation is in flight at a
// time: accept in IDLE, evaluate the ALU in EXEC, hold the result in RESP
// until the owning port takes it.
module alu_sched
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = OPW_DEF
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,

    output logic [OPW-1:0]  alu_opcode,
    output logic [XLEN-1:0] alu_imm1,
    output logic [XLEN-1:0] alu_imm2,
    input  logic [XLEN-1:0] alu_result
);

    sched_state_t    state_r;
    sched_state_t    state_nxt_s;

    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] res_q;
    logic            owner_q;
    logic            prio_q;

    logic [1:0]      grant_s;
    logic            hs_s;
    logic            rsp_fire_s;
    logic            op_legal_s;
    logic [OPW-1:0]  sel_op_s;
    logic [XLEN-1:0] sel_a_s;
    logic [XLEN-1:0] sel_b_s;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .prio  (prio_q),
        .grant (grant_s)
    );

    // Grant is only offered while idle; the winner sees ready this cycle
    assign req0_ready = (state_r == ST_IDLE) && grant_s[0];
    assign req1_ready = (state_r == ST_IDLE) && grant_s[1];
    assign hs_s       = (state_r == ST_IDLE) && (grant_s != 2'b00);

    // Payload of the granted port
    assign sel_op_s = grant_s[1] ? req1_op : req0_op;
    assign sel_a_s  = grant_s[1] ? req1_a  : req0_a;
    assign sel_b_s  = grant_s[1] ? req1_b  : req0_b;

    // Out-of-range opcodes complete with a zero result regardless of the ALU
    assign op_legal_s = (op_q <= OPW'(ALU_OP_LAST));

    // Shared ALU is driven from the captured operands only
    assign alu_opcode = op_q;
    assign alu_imm1   = a_q;
    assign alu_imm2   = b_q;

    // Only the owner's valid qualifies the common result bus
    assign rsp0_valid  = (state_r == ST_RESP) && !owner_q;
    assign rsp1_valid  = (state_r == ST_RESP) &&  owner_q;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;

    // Response is consumed when the owning port's consumer is ready
    always_comb begin
        rsp_fire_s = 1'b0;
        if (owner_q) begin
            rsp_fire_s = rsp1_valid && rsp1_ready;
        end else begin
            rsp_fire_s = rsp0_valid && rsp0_ready;
        end
    end

    // Scheduler next-state: IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture on handshake, result capture in EXEC, tie-break update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= {OPW{1'b0}};
            a_q     <= {XLEN{1'b0}};
            b_q     <= {XLEN{1'b0}};
            res_q   <= {XLEN{1'b0}};
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            if (hs_s) begin
                op_q    <= sel_op_s;
                a_q     <= sel_a_s;
                b_q     <= sel_b_s;
                owner_q <= grant_s[1];
                prio_q  <= ~grant_s[1];
            end
            if (state_r == ST_EXEC) begin
                res_q <= op_legal_s ? alu_result : {XLEN{1'b0}};
            end
        end
    end

endmodule
